regfile_wb_ctrl: RTL
====================

# regfile_wb_ctrl

Writeback initiator for the 19-bit register file. It accepts register write requests from the ALU (port A) and the load unit (port B) over valid/ready handshakes and round-robin arbitrates between them. Accepted writes are buffered in a small in-order queue and drained one per cycle onto the register file write port. Decode can look up pending writes, so operands are forwarded before they reach the array.

## Interface
- DATA_W, 19, register data width
- ADDR_W, 5, register address width
- DEPTH, 4, writeback queue entries (power of two, ≥2)

- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-low
- a_valid / a_ready  in / out  1 / 1  ALU request handshake
- a_addr / a_data  in  ADDR_W / DATA_W  ALU destination / value
- b_valid / b_ready  in / out  1 / 1  load-unit request handshake
- b_addr / b_data  in  ADDR_W / DATA_W  load destination / value
- rf_busy  in  1  register file write port unavailable; suppresses drain
- rf_we  out  1  write_enable to register file (registered)
- rf_waddr  out  ADDR_W  write_addr (registered)
- rf_wdata  out  DATA_W  write_data (registered)
- fwd_addr1, fwd_addr2  in  ADDR_W  decode read addresses
- fwd_hit1, fwd_hit2  out  1  pending write exists for that address
- fwd_data1, fwd_data2  out  DATA_W  youngest pending value
- count  out  $clog2(DEPTH+1)  queue occupancy

## Operation
- Reset (rst=0 at an edge) has these effects:
  - queue cleared and count=0;
  - rf_we=0, rf_waddr=0, rf_wdata=0;
  - last_grant=A, so B wins first contention.
- Readiness: a_ready and b_ready are 0 when count==DEPTH or while rst=0.
- When not full, only one request is accepted per cycle:
  - if only one source is valid, it gets ready=1;
  - if both are valid, the source not granted last gets ready=1 and the other gets ready=0;
  - last_grant updates only on contention.
- r0 reads as zero. A write to addr 0 completes its handshake but is dropped:
  - it is not enqueued, count is unchanged and last_grant still updates;
  - it never produces rf_we or a forward hit.
- Drain: on each edge where the queue is non-empty and rf_busy=0, the head is popped into rf_waddr/rf_wdata with rf_we=1. Otherwise rf_we=0 next cycle and the address/data registers hold.
- The register file consumes every cycle with rf_we=1. rf_busy only blocks new pops.
- Push and pop may occur on the same edge; count stays the same.
- Ordering: strict FIFO. Writes to the same address reach the file in acceptance order.
- Forwarding is combinational. It searches queue entries youngest-first, then the rf_w* stage when rf_we=1:
  - the first match gives hit=1 and that data;
  - fwd_addr==0 always gives hit=0 and data=0;
  - a request being accepted this cycle is not visible.
- No arithmetic on data; widths pass through unchanged.

## Timing
- Request accepted at edge k into an empty queue with rf_busy=0 at k+1:
  - rf_we=1 with its address/data during cycle k+1→k+2;
  - the register file stores it at edge k+2.
- Forward visibility: from cycle k+1 (after the accept edge) until edge k+2, inclusive of the rf_w* stage.
- Sustained throughput is 1 write/cycle with no bubbles while rf_busy=0.
- Full boundary: readies drop in the cycle count==DEPTH. They do not anticipate a same-cycle pop, so readiness returns one cycle after a pop.
- rf_busy asserted mid-stream: the write already presented completes, and the next cycle shows rf_we=0.
- Reset mid-operation: all queued writes are discarded and nothing further is issued.

## Structure
- Shared package regfile_pkg holds:
  - DATA_W and ADDR_W constants;
  - the wb_req_t struct {addr, data};
  - the src_t enum {SRC_A, SRC_B} for last_grant.
- Sub-module regfile_wb_fifo:
  - synchronous circular FIFO of wb_req_t with head/tail pointers and count;
  - exports all entries plus a valid mask to the parent's forwarding mux.
- Arbitration, drain register and forwarding priority live in regfile_wb_ctrl.

## Test plan
- Reset: rst=0 for 2 cycles with a_valid=1 → a_ready=0, rf_we=0, count=0. After release, a_ready=1.
- Single write: accept A addr 5, data 19'b1010101010101010101 at edge k → rf_we=1, rf_waddr=5, rf_wdata=0x55555 for exactly cycle k+1. fwd_addr1=5 gives hit1=1 in that cycle.
- Contention: both valid (A→3/0x00011, B→4/0x00022) → B is accepted first, then A. rf writes issue in order 4, then 3 on consecutive cycles.
- Full plus forwarding: rf_busy=1, push 10/0x00001, 7/0x00002, 10/0x7FFFF, 9/0x00003 → count=4 and both readies 0. fwd_addr2=10 gives 0x7FFFF. Release rf_busy → drains 10, 7, 10, 9 with no gaps.
- r0: write addr 0 data 0x12345 → handshake completes, count stays 0, rf_we stays 0, fwd hit=0.
- Mid-reset: 3 queued with rf_busy=1, then rst=0 one cycle → count=0, and no rf_we pulses after rf_busy drops.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file writeback path.
package regfile_pkg;

  localparam int DATA_W = 19;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [0:0] {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// In-order circular queue of pending register writes.
// Every slot and its occupancy bit are exposed so the parent can forward from them.
module regfile_wb_fifo
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_req_t          push_req,
  input  logic             pop,
  output wb_req_t          head_req,
  output logic [PTR_W-1:0] head_ptr,
  output logic [CNT_W-1:0] count,
  output wb_req_t          entries [DEPTH],
  output logic [DEPTH-1:0] entry_valid
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  wb_req_t          mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;
  logic [PTR_W-1:0] age_s;

  assign do_push_s = push && (count_r != CNT_FULL);
  assign do_pop_s  = pop && (count_r != '0);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage; slots are qualified by entry_valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_req;
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    entry_valid = '0;
    age_s       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_s          = PTR_W'(i) - rd_ptr_r;
      entry_valid[i] = (CNT_W'(age_s) < count_r);
    end
  end

  assign head_req = mem_r[rd_ptr_r];
  assign head_ptr = rd_ptr_r;
  assign count    = count_r;
  assign entries  = mem_r;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback initiator: round-robin between ALU and load unit, queue, drain, forward.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              rf_busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] fwd_addr1,
  input  logic [ADDR_W-1:0] fwd_addr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  src_t              last_grant_r;
  logic              a_ready_s;
  logic              b_ready_s;
  logic              full_s;
  logic              contention_s;
  logic              push_s;
  logic              pop_s;
  wb_req_t           push_req_s;
  wb_req_t           head_req_s;
  logic [PTR_W-1:0]  head_ptr_s;
  logic [CNT_W-1:0]  count_s;
  wb_req_t           entries_s [DEPTH];
  logic [DEPTH-1:0]  entry_valid_s;
  logic              rf_we_r;
  logic [ADDR_W-1:0] rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r;
  logic [ADDR_W-1:0] fwd_addr_s [2];
  logic              fwd_hit_s  [2];
  logic [DATA_W-1:0] fwd_data_s [2];
  logic [PTR_W-1:0]  idx_s;

  assign full_s       = (count_s == CNT_FULL);
  assign contention_s = rst && !full_s && a_valid && b_valid;

  // Readiness never anticipates a same-cycle pop, so a full queue stalls both sources.
  always_comb begin
    a_ready_s = 1'b0;
    b_ready_s = 1'b0;
    if (!rst || full_s) begin
      a_ready_s = 1'b0;
      b_ready_s = 1'b0;
    end else if (a_valid && b_valid) begin
      a_ready_s = (last_grant_r == SRC_B);
      b_ready_s = (last_grant_r == SRC_A);
    end else begin
      a_ready_s = a_valid;
      b_ready_s = b_valid;
    end
  end

  // Round-robin history only moves when both sources competed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_r <= SRC_A;
    end else if (contention_s) begin
      last_grant_r <= b_ready_s ? SRC_B : SRC_A;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Select the granted request; writes to r0 handshake but are never queued.
  always_comb begin
    push_req_s = '0;
    push_s     = 1'b0;
    if (a_ready_s) begin
      push_req_s.addr = a_addr;
      push_req_s.data = a_data;
      push_s          = (a_addr != '0);
    end else if (b_ready_s) begin
      push_req_s.addr = b_addr;
      push_req_s.data = b_data;
      push_s          = (b_addr != '0);
    end else begin
      push_req_s = '0;
      push_s     = 1'b0;
    end
  end

  assign pop_s = (count_s != '0) && !rf_busy;

  regfile_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push_s),
    .push_req    (push_req_s),
    .pop         (pop_s),
    .head_req    (head_req_s),
    .head_ptr    (head_ptr_s),
    .count       (count_s),
    .entries     (entries_s),
    .entry_valid (entry_valid_s)
  );

  // Drain stage: rf_we is a one-cycle pulse per pop; address/data hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= '0;
      rf_wdata_r <= '0;
    end else if (pop_s) begin
      rf_we_r    <= 1'b1;
      rf_waddr_r <= head_req_s.addr;
      rf_wdata_r <= head_req_s.data;
    end else begin
      rf_we_r    <= 1'b0;
    end
  end

  assign fwd_addr_s[0] = fwd_addr1;
  assign fwd_addr_s[1] = fwd_addr2;

  // Scan oldest-to-youngest so the last match (youngest) wins; drain stage is oldest.
  always_comb begin
    idx_s = '0;
    for (int p = 0; p < 2; p++) begin
      fwd_hit_s[p]  = 1'b0;
      fwd_data_s[p] = '0;
      if (fwd_addr_s[p] != '0) begin
        if (rf_we_r && (rf_waddr_r == fwd_addr_s[p])) begin
          fwd_hit_s[p]  = 1'b1;
          fwd_data_s[p] = rf_wdata_r;
        end else begin
          fwd_hit_s[p]  = 1'b0;
          fwd_data_s[p] = '0;
        end
        for (int k = 0; k < DEPTH; k++) begin
          idx_s = head_ptr_s + PTR_W'(k);
          if (entry_valid_s[idx_s] && (entries_s[idx_s].addr == fwd_addr_s[p])) begin
            fwd_hit_s[p]  = 1'b1;
            fwd_data_s[p] = entries_s[idx_s].data;
          end else begin
            fwd_hit_s[p]  = fwd_hit_s[p];
            fwd_data_s[p] = fwd_data_s[p];
          end
        end
      end else begin
        fwd_hit_s[p]  = 1'b0;
        fwd_data_s[p] = '0;
      end
    end
  end

  assign a_ready   = a_ready_s;
  assign b_ready   = b_ready_s;
  assign rf_we     = rf_we_r;
  assign rf_waddr  = rf_waddr_r;
  assign rf_wdata  = rf_wdata_r;
  assign fwd_hit1  = fwd_hit_s[0];
  assign fwd_hit2  = fwd_hit_s[1];
  assign fwd_data1 = fwd_data_s[0];
  assign fwd_data2 = fwd_data_s[1];
  assign count     = count_s;

endmodule
